// File: rtl/tmr_err_monitor.sv
// tmr_err_monitor
//   Consumes the tmrErr flags of the triplicated-register majority voters.
//   Provides:
//     - per-voter sticky error status;
//     - a saturating error-event counter;
//     - a level interrupt;
//     - a scrub request raised when voter disagreement persists.
//
// Parameters
//   NUM_VOTERS     number of voter tmrErr inputs (1..32)
//   CNT_WIDTH      width of the error-event counter
//   PERSIST_CYCLES consecutive error cycles that trigger a scrub request (>=1)
//   HOLDOFF_CYCLES cycles after scrub ack with persistence detection off (>=1)
//
// Ports
//   clk           in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   tmr_err_i     in   one tmrErr flag per voter (combinational from voters)
//   clr_i         in   synchronous clear of counter, saturation and sticky bits
//   scrub_ack_i   in   scrub controller acknowledges the request
//   err_sticky_o  out  per-voter sticky error flags
//   err_count_o   out  error-event count (saturating)
//   count_sat_o   out  counter has reached its maximum
//   irq_o         out  level interrupt, OR of err_sticky_o
//   scrub_req_o   out  scrub request, held until acknowledged
module tmr_err_monitor #(
  parameter int unsigned NUM_VOTERS     = 4,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned PERSIST_CYCLES = 3,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_VOTERS-1:0] tmr_err_i,
  input  logic                  clr_i,
  input  logic                  scrub_ack_i,
  output logic [NUM_VOTERS-1:0] err_sticky_o,
  output logic [CNT_WIDTH-1:0]  err_count_o,
  output logic                  count_sat_o,
  output logic                  irq_o,
  output logic                  scrub_req_o
);

  localparam int unsigned PCNT_W = (PERSIST_CYCLES > 1) ? $clog2(PERSIST_CYCLES) : 1;
  localparam int unsigned HCNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
  localparam logic [PCNT_W-1:0]    PCNT_LAST    = PCNT_W'(PERSIST_CYCLES - 1);
  localparam logic [HCNT_W-1:0]    HCNT_LAST    = HCNT_W'(HOLDOFF_CYCLES - 1);
  localparam bit                   PERSIST_ONE  = (PERSIST_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_REQ,
    ST_HOLDOFF
  } state_e;

  // Input stage and history
  logic [NUM_VOTERS-1:0] err_q, err_d;
  logic [NUM_VOTERS-1:0] err_qq, err_qq_d;

  // Status
  logic [NUM_VOTERS-1:0] sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  sat_q, sat_d;
  logic                  irq_q, irq_d;

  // Scrub FSM
  state_e                state_q, state_d;
  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
  logic                  scrub_req_q, scrub_req_d;

  logic                  any_err;
  logic                  err_event;

  assign any_err   = |err_q;
  // An event is any voter flag rising; several simultaneous rises count once.
  assign err_event = |(err_q & ~err_qq);

  // Datapath next state
  always_comb begin
    err_d    = tmr_err_i;
    err_qq_d = err_q;

    // Sticky set takes priority over clear.
    if (clr_i) begin
      sticky_d = err_q;
    end else begin
      sticky_d = sticky_q | err_q;
    end
    irq_d = |sticky_d;

    // A clear coinciding with an event restarts the count at 1.
    count_d = count_q;
    if (clr_i) begin
      count_d = err_event ? CNT_WIDTH'(1) : '0;
    end else if (err_event && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
    sat_d = (count_d == CNT_MAX);
  end

  // Scrub FSM next state
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_err) begin
          if (PERSIST_ONE) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_COUNT;
            pcnt_d  = PCNT_W'(1);
          end
        end
      end

      ST_COUNT: begin
        if (!any_err) begin
          state_d = ST_IDLE;
          pcnt_d  = '0;
        end else if (pcnt_q == PCNT_LAST) begin
          state_d = ST_REQ;
          pcnt_d  = '0;
        end else begin
          pcnt_d  = pcnt_q + PCNT_W'(1);
        end
      end

      ST_REQ: begin
        if (scrub_ack_i) begin
          state_d = ST_HOLDOFF;
          hcnt_d  = '0;
        end
      end

      ST_HOLDOFF: begin
        if (hcnt_q == HCNT_LAST) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d  = hcnt_q + HCNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase

    // Registered decode of the next state keeps the request glitch-free and
    // lets it drop on the same edge that samples the acknowledge.
    scrub_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= '0;
      err_qq      <= '0;
      sticky_q    <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      irq_q       <= 1'b0;
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      scrub_req_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      err_qq      <= err_qq_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      irq_q       <= irq_d;
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      hcnt_q      <= hcnt_d;
      scrub_req_q <= scrub_req_d;
    end
  end

  assign err_sticky_o = sticky_q;
  assign err_count_o  = count_q;
  assign count_sat_o  = sat_q;
  assign irq_o        = irq_q;
  assign scrub_req_o  = scrub_req_q;

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Directed bench for tmr_err_monitor: one instance with default parameters,
// a second with CNT_WIDTH=3 for counter saturation.
module tb_tmr_err_monitor;

  logic        clk;
  logic        rst_n;

  logic [3:0]  te;
  logic        clr;
  logic        ack;
  logic [3:0]  sticky;
  logic [15:0] count;
  logic        sat;
  logic        irq;
  logic        req;

  logic [3:0]  te_s;
  logic        clr_s;
  logic        ack_s;
  logic [3:0]  sticky_s;
  logic [2:0]  count_s;
  logic        sat_s;
  logic        irq_s;
  logic        req_s;

  int          n_checks;
  int          n_errors;

  tmr_err_monitor #(
    .NUM_VOTERS    (4),
    .CNT_WIDTH     (16),
    .PERSIST_CYCLES(3),
    .HOLDOFF_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tmr_err_i   (te),
    .clr_i       (clr),
    .scrub_ack_i (ack),
    .err_sticky_o(sticky),
    .err_count_o (count),
    .count_sat_o (sat),
    .irq_o       (irq),
    .scrub_req_o (req)
  );

  tmr_err_monitor #(
    .NUM_VOTERS    (4),
    .CNT_WIDTH     (3),
    .PERSIST_CYCLES(3),
    .HOLDOFF_CYCLES(8)
  ) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .tmr_err_i   (te_s),
    .clr_i       (clr_s),
    .scrub_ack_i (ack_s),
    .err_sticky_o(sticky_s),
    .err_count_o (count_s),
    .count_sat_o (sat_s),
    .irq_o       (irq_s),
    .scrub_req_o (req_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sticky"}, 32'(sticky), 32'h0);
    chk({tag, "_count"},  32'(count),  32'h0);
    chk({tag, "_sat"},    32'(sat),    32'h0);
    chk({tag, "_irq"},    32'(irq),    32'h0);
    chk({tag, "_req"},    32'(req),    32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    te    = 4'hF;
    clr   = 1'b0;
    ack   = 1'b0;
    te_s  = 4'h0;
    clr_s = 1'b0;
    ack_s = 1'b0;

    // Reset held with errors on the inputs: outputs stay 0.
    tick(); tick(); tick();
    chk_all_zero("rst_held");

    // Release with quiet inputs: no false event.
    te    = 4'h0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk_all_zero("rst_release");

    // Single pulse on bit 2: visible two edges after it is driven.
    te = 4'b0100;
    tick();
    te = 4'h0;
    chk("pulse_lat_sticky", 32'(sticky), 32'h0);
    chk("pulse_lat_count",  32'(count),  32'h0);
    tick();
    chk("pulse_sticky", 32'(sticky), 32'h4);
    chk("pulse_irq",    32'(irq),    32'h1);
    chk("pulse_count",  32'(count),  32'h1);
    chk("pulse_req",    32'(req),    32'h0);
    tick(); tick(); tick();
    chk("pulse_req_late",   32'(req),   32'h0);
    chk("pulse_count_late", 32'(count), 32'h1);

    // Clear with no event pending.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_sticky", 32'(sticky), 32'h0);
    chk("clr_count",  32'(count),  32'h0);
    chk("clr_irq",    32'(irq),    32'h0);

    // Persistence: three consecutive error cycles on bit 0.
    te = 4'b0001;
    tick(); tick(); tick();
    te = 4'h0;
    chk("persist_req_early", 32'(req), 32'h0);
    tick();
    chk("persist_req_rise", 32'(req),    32'h1);
    chk("persist_count",    32'(count),  32'h1);
    chk("persist_sticky",   32'(sticky), 32'h1);
    tick(); tick();
    chk("persist_req_hold", 32'(req), 32'h1);

    // Acknowledge drops the request on the sampling edge.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_req_fall", 32'(req), 32'h0);

    // Holdoff: inputs 1,1,1,1,0,1,0,0 over 8 edges; two rising events.
    for (int unsigned i = 0; i < 8; i++) begin
      te = (i < 4 || i == 5) ? 4'b0001 : 4'b0000;
      tick();
      chk("holdoff_req", 32'(req), 32'h0);
    end
    te = 4'h0;
    tick();
    chk("holdoff_count", 32'(count), 32'h3);
    tick(); tick(); tick();
    chk("post_holdoff_req", 32'(req), 32'h0);

    // Broken run 1,1,0,1,1 on bit 0: never requests, two events.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("broken_clr_count", 32'(count), 32'h0);
    for (int unsigned i = 0; i < 9; i++) begin
      te = (i < 5 && i != 2) ? 4'b0001 : 4'b0000;
      tick();
      chk("broken_req", 32'(req), 32'h0);
    end
    chk("broken_count", 32'(count), 32'h2);

    // Clear in the same cycle as a new event on bit 1.
    te = 4'b0010;
    tick();
    te  = 4'h0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrset_count",  32'(count),  32'h1);
    chk("clrset_sticky", 32'(sticky), 32'h2);
    chk("clrset_irq",    32'(irq),    32'h1);
    chk("clrset_sat",    32'(sat),    32'h0);
    tick(); tick();

    // Reset asserted while the request is up: outputs drop without a clock.
    te = 4'b1000;
    tick(); tick(); tick();
    te = 4'h0;
    tick();
    chk("midreq_req_up", 32'(req), 32'h1);
    rst_n = 1'b0;
    #2;
    chk_all_zero("midreq_async");
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk_all_zero("midreq_release");

    // Saturation with CNT_WIDTH=3: nine separated pulses, count stops at 7.
    for (int unsigned i = 0; i < 9; i++) begin
      te_s = 4'b0001;
      tick();
      te_s = 4'h0;
      tick();
      chk("sat_count", 32'(count_s), (i < 7) ? (i + 1) : 32'd7);
      chk("sat_flag",  32'(sat_s),   (i >= 6) ? 32'd1 : 32'd0);
    end
    chk("sat_req", 32'(req_s), 32'h0);
    clr_s = 1'b1;
    tick();
    clr_s = 1'b0;
    chk("sat_clr_count", 32'(count_s), 32'h0);
    chk("sat_clr_flag",  32'(sat_s),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
